// File: rtl/apb_master_arbiter1.sv
// Round-robin arbiter sharing one APB master port among NUM_REQ requesters.
// Optional ACCESS wait timeout enabled by defining APB_ARB_TIMEOUT_EN.
module apb_master_arbiter1 #(
    parameter int NUM_REQ        = 4,
    parameter int PADDR_WIDTH1   = 32,
    parameter int PWDATA_WIDTH1  = 32,
    parameter int PRDATA_WIDTH1  = 32,
    parameter int SEL_LSB        = 28,
    parameter int TIMEOUT_CYCLES = 256
) (
    input  logic                               pclock1,
    input  logic                               preset1,
    input  logic [NUM_REQ-1:0]                 req_valid,
    input  logic [NUM_REQ-1:0]                 req_write,
    input  logic [NUM_REQ*PADDR_WIDTH1-1:0]    req_addr,
    input  logic [NUM_REQ*PWDATA_WIDTH1-1:0]   req_wdata,
    output logic [NUM_REQ-1:0]                 req_done,
    output logic [PRDATA_WIDTH1-1:0]           rsp_rdata,
    output logic                               rsp_slverr,
    output logic                               rsp_timeout,
    output logic [PADDR_WIDTH1-1:0]            paddr1,
    output logic                               prwd1,
    output logic [PWDATA_WIDTH1-1:0]           pwdata1,
    output logic [15:0]                        psel1,
    output logic                               penable1,
    input  logic                               pready1,
    input  logic [PRDATA_WIDTH1-1:0]           prdata1,
    input  logic                               pslverr1
);
    localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2
    } state_t;

    state_t                     state_r, state_s;
    logic [IW-1:0]              ptr_r, ptr_s, grant_r, grant_s, win_s;
    logic                       found_s;
    logic [NUM_REQ-1:0]         elig_s;
    logic [PADDR_WIDTH1-1:0]    win_addr_s, paddr_s;
    logic [PWDATA_WIDTH1-1:0]   pwdata_s;
    logic                       prwd_s, penable_s, rsp_slverr_s, rsp_timeout_s;
    logic [15:0]                psel_s;
    logic [NUM_REQ-1:0]         req_done_s;
    logic [PRDATA_WIDTH1-1:0]   rsp_rdata_s;

`ifdef APB_ARB_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    logic [TW-1:0] to_cnt_r, to_cnt_s;
`endif

    // The requester pulsing done this cycle is masked so it cannot win again immediately.
    assign elig_s = req_valid & ~req_done;

    // Round-robin search starting at the priority pointer, wrapping at NUM_REQ.
    always_comb begin
        found_s = 1'b0;
        win_s   = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            int idx;
            idx = int'(ptr_r) + k;
            if (idx >= NUM_REQ) begin
                idx = idx - NUM_REQ;
            end else begin
                idx = idx;
            end
            if (!found_s && elig_s[idx]) begin
                found_s = 1'b1;
                win_s   = idx[IW-1:0];
            end else begin
                found_s = found_s;
            end
        end
    end

    assign win_addr_s = req_addr[int'(win_s)*PADDR_WIDTH1 +: PADDR_WIDTH1];

    // Next-state and next-output logic for the SETUP/ACCESS sequencer.
    always_comb begin
        state_s       = state_r;
        ptr_s         = ptr_r;
        grant_s       = grant_r;
        paddr_s       = paddr1;
        prwd_s        = prwd1;
        pwdata_s      = pwdata1;
        psel_s        = psel1;
        penable_s     = penable1;
        req_done_s    = '0;
        rsp_rdata_s   = rsp_rdata;
        rsp_slverr_s  = rsp_slverr;
        rsp_timeout_s = rsp_timeout;
`ifdef APB_ARB_TIMEOUT_EN
        to_cnt_s      = to_cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (found_s) begin
                    grant_s  = win_s;
                    ptr_s    = (win_s == IW'(NUM_REQ - 1)) ? '0 : win_s + IW'(1);
                    paddr_s  = win_addr_s;
                    prwd_s   = req_write[win_s];
                    pwdata_s = req_wdata[int'(win_s)*PWDATA_WIDTH1 +: PWDATA_WIDTH1];
                    psel_s   = 16'h0001 << win_addr_s[SEL_LSB +: 4];
                    state_s  = SETUP;
                end else begin
                    state_s  = IDLE;
                end
            end
            SETUP: begin
                penable_s = 1'b1;
                state_s   = ACCESS;
`ifdef APB_ARB_TIMEOUT_EN
                to_cnt_s  = '0;
`endif
            end
            ACCESS: begin
                if (pready1) begin
                    rsp_rdata_s         = prwd1 ? '0 : prdata1;
                    rsp_slverr_s        = pslverr1;
                    rsp_timeout_s       = 1'b0;
                    req_done_s[grant_r] = 1'b1;
                    psel_s              = 16'h0000;
                    penable_s           = 1'b0;
                    state_s             = IDLE;
`ifdef APB_ARB_TIMEOUT_EN
                end else if (to_cnt_r == TO_LAST) begin
                    rsp_rdata_s         = '0;
                    rsp_slverr_s        = 1'b1;
                    rsp_timeout_s       = 1'b1;
                    req_done_s[grant_r] = 1'b1;
                    psel_s              = 16'h0000;
                    penable_s           = 1'b0;
                    state_s             = IDLE;
                end else begin
                    to_cnt_s = to_cnt_r + TW'(1);
                end
`else
                end else begin
                    rsp_timeout_s = 1'b0;
                end
`endif
            end
            default: begin
                psel_s    = 16'h0000;
                penable_s = 1'b0;
                state_s   = IDLE;
            end
        endcase
    end

    // State, pointer and grant registers.
    always_ff @(posedge pclock1 or negedge preset1) begin
        if (!preset1) begin
            state_r <= IDLE;
            ptr_r   <= '0;
            grant_r <= '0;
        end else begin
            state_r <= state_s;
            ptr_r   <= ptr_s;
            grant_r <= grant_s;
        end
    end

    // Registered APB and response outputs.
    always_ff @(posedge pclock1 or negedge preset1) begin
        if (!preset1) begin
            paddr1      <= '0;
            prwd1       <= 1'b0;
            pwdata1     <= '0;
            psel1       <= 16'h0000;
            penable1    <= 1'b0;
            req_done    <= '0;
            rsp_rdata   <= '0;
            rsp_slverr  <= 1'b0;
            rsp_timeout <= 1'b0;
        end else begin
            paddr1      <= paddr_s;
            prwd1       <= prwd_s;
            pwdata1     <= pwdata_s;
            psel1       <= psel_s;
            penable1    <= penable_s;
            req_done    <= req_done_s;
            rsp_rdata   <= rsp_rdata_s;
            rsp_slverr  <= rsp_slverr_s;
            rsp_timeout <= rsp_timeout_s;
        end
    end

`ifdef APB_ARB_TIMEOUT_EN
    // ACCESS wait counter.
    always_ff @(posedge pclock1 or negedge preset1) begin
        if (!preset1) begin
            to_cnt_r <= '0;
        end else begin
            to_cnt_r <= to_cnt_s;
        end
    end
`endif

endmodule

// File: tb/tb_apb_master_arbiter1.sv
// Directed plus randomized bench for apb_master_arbiter1 against a transaction-level model.
module tb_apb_master_arbiter1;
    localparam int N = 4;

    logic              pclock1, preset1;
    logic [N-1:0]      req_valid, req_write, req_done;
    logic [N*32-1:0]   req_addr, req_wdata;
    logic [31:0]       rsp_rdata, paddr1, pwdata1, prdata1;
    logic              rsp_slverr, rsp_timeout, prwd1, penable1, pready1, pslverr1;
    logic [15:0]       psel1;

    logic [31:0]       a_addr  [N];
    logic [31:0]       a_wdata [N];
    int                tests, fails;
    int                ptr_m;
    logic [N-1:0]      done_m;

    apb_master_arbiter1 #(
        .NUM_REQ(N), .PADDR_WIDTH1(32), .PWDATA_WIDTH1(32), .PRDATA_WIDTH1(32),
        .SEL_LSB(28), .TIMEOUT_CYCLES(8)
    ) dut (
        .pclock1(pclock1), .preset1(preset1),
        .req_valid(req_valid), .req_write(req_write), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_done(req_done), .rsp_rdata(rsp_rdata), .rsp_slverr(rsp_slverr), .rsp_timeout(rsp_timeout),
        .paddr1(paddr1), .prwd1(prwd1), .pwdata1(pwdata1), .psel1(psel1), .penable1(penable1),
        .pready1(pready1), .prdata1(prdata1), .pslverr1(pslverr1)
    );

    initial pclock1 = 1'b0;
    always #5 pclock1 = ~pclock1;

    always_comb begin
        req_addr  = '0;
        req_wdata = '0;
        for (int i = 0; i < N; i++) begin
            req_addr[i*32 +: 32]  = a_addr[i];
            req_wdata[i*32 +: 32] = a_wdata[i];
        end
    end

    task automatic tick();
        @(posedge pclock1);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic rand_req(input int i);
        a_addr[i]    = $urandom;
        a_wdata[i]   = $urandom;
        req_write[i] = 1'($urandom_range(0, 1));
    endtask

    // Model: first requester with valid set and no done pulse, scanning from the pointer.
    function automatic int pick(input logic [N-1:0] v, input logic [N-1:0] d, input int p);
        for (int k = 0; k < N; k++) begin
            int i;
            i = (p + k) % N;
            if (v[i] && !d[i]) return i;
        end
        return -1;
    endfunction

    // One transaction from an IDLE cycle; raise/drop alter req_valid during ACCESS.
    task automatic serve(input int waits, input bit err, input logic [31:0] rd,
                         input logic [N-1:0] raise, input logic [N-1:0] drop, output int w);
        logic [31:0] ea, ewd;
        logic        ew;
        logic [15:0] es;
        w = pick(req_valid, done_m, ptr_m);
        if (w < 0) begin
            tick();
            done_m = '0;
            chk("idle_psel", psel1, 0);
            chk("idle_done", req_done, 0);
            return;
        end
        ea  = a_addr[w];
        ewd = a_wdata[w];
        ew  = req_write[w];
        es  = 16'h0001 << ea[31:28];
        tick();
        done_m = '0;
        chk("setup_psel", psel1, es);
        chk("setup_penable", penable1, 0);
        chk("setup_paddr", paddr1, ea);
        chk("setup_prwd", prwd1, ew);
        chk("setup_pwdata", pwdata1, ewd);
        chk("setup_done", req_done, 0);
        tick();
        for (int n = 0; n <= waits; n++) begin
            chk("acc_penable", penable1, 1);
            chk("acc_psel", psel1, es);
            chk("acc_paddr", paddr1, ea);
            chk("acc_pwdata", pwdata1, ewd);
            chk("acc_done", req_done, 0);
            if (n == 0) req_valid = req_valid | raise;
            if (n == waits) req_valid = req_valid & ~drop;
            pready1  = (n == waits);
            prdata1  = rd;
            pslverr1 = (n == waits) ? err : 1'($urandom_range(0, 1));
            tick();
        end
        pready1  = 1'b0;
        pslverr1 = 1'b0;
        chk("done_vec", req_done, 4'b0001 << w);
        chk("done_rdata", rsp_rdata, ew ? 32'h0 : rd);
        chk("done_slverr", rsp_slverr, err);
        chk("done_timeout", rsp_timeout, 0);
        chk("done_psel", psel1, 0);
        chk("done_penable", penable1, 0);
        done_m = 4'b0001 << w;
        ptr_m  = (w + 1) % N;
    endtask

    initial begin
        int w, lw;
        logic [N-1:0] nm;
        logic [15:0] es;
        tests = 0; fails = 0;
        ptr_m = 0; done_m = '0;
        preset1 = 1'b0; pready1 = 1'b0; prdata1 = '0; pslverr1 = 1'b0;
        req_write = '0;
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = 4'b1111;
        repeat (3) tick();
        chk("rst_psel", psel1, 0);
        chk("rst_penable", penable1, 0);
        chk("rst_paddr", paddr1, 0);
        chk("rst_prwd", prwd1, 0);
        chk("rst_pwdata", pwdata1, 0);
        chk("rst_done", req_done, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_slverr", rsp_slverr, 0);
        chk("rst_timeout", rsp_timeout, 0);
        req_valid = '0;
        preset1 = 1'b1;
        tick();

        // Single read from requester 0.
        a_addr[0] = 32'h3000_0010; req_write[0] = 1'b0;
        req_valid = 4'b0001;
        serve(0, 1'b0, 32'hCAFE_F00D, 4'b0000, 4'b0000, w);
        req_valid = '0;

        // Write with three wait states and a slave error.
        a_addr[1] = 32'h1000_0004; a_wdata[1] = 32'h1234_5678; req_write[1] = 1'b1;
        req_valid = 4'b0010;
        serve(3, 1'b1, $urandom, 4'b0000, 4'b0000, w);
        req_valid = '0;

        // Requester 2 withdraws before grant; requester 0 drops valid after its grant.
        rand_req(0); rand_req(2); rand_req(3);
        req_valid = 4'b0001;
        serve(2, 1'b0, $urandom, 4'b1100, 4'b0101, w);
        serve(0, 1'b0, $urandom, 4'b0000, 4'b0000, w);
        req_valid = '0;
        for (int k = 0; k < 5; k++) begin
            tick();
            done_m = '0;
            chk("withdrawn_no_done", req_done, 0);
        end

        // Asynchronous reset in the middle of ACCESS.
        rand_req(1);
        req_valid = 4'b0010;
        tick();
        tick();
        #2 preset1 = 1'b0;
        #1;
        chk("mid_rst_psel", psel1, 0);
        chk("mid_rst_penable", penable1, 0);
        chk("mid_rst_paddr", paddr1, 0);
        chk("mid_rst_done", req_done, 0);
        chk("mid_rst_rdata", rsp_rdata, 0);
        for (int i = 0; i < N; i++) rand_req(i);
        req_valid = 4'b1111;
        tick();
        tick();
        preset1 = 1'b1;
        ptr_m = 0; done_m = '0;

        // All requesters continuously requesting: rotation starts at 0 after reset.
        for (int k = 0; k < 5; k++) begin
            serve($urandom_range(0, 2), 1'b0, $urandom, 4'b0000, 4'b0000, w);
            if (w >= 0) rand_req(w);
        end

        // Randomized request masks.
        lw = w;
        for (int k = 0; k < 40; k++) begin
            nm = 4'($urandom_range(0, 15));
            for (int i = 0; i < N; i++) begin
                if (!req_valid[i] || i == lw) rand_req(i);
            end
            req_valid = nm;
            serve($urandom_range(0, 3), 1'($urandom_range(0, 1)), $urandom, 4'b0000, 4'b0000, lw);
        end

        // Slave never ready.
        req_valid = '0;
        tick();
        done_m = '0;
        rand_req(2);
        req_valid = 4'b0100;
        w  = pick(req_valid, done_m, ptr_m);
        es = 16'h0001 << a_addr[2][31:28];
        pready1 = 1'b0;
        tick();
        tick();
`ifdef APB_ARB_TIMEOUT_EN
        begin
            int c;
            c = 0;
            for (int k = 1; k <= 50 && c == 0; k++) begin
                tick();
                if (req_done !== '0) c = k;
            end
            chk("to_cycles", c, 8);
            chk("to_done_vec", req_done, 4'b0001 << w);
            chk("to_slverr", rsp_slverr, 1);
            chk("to_timeout", rsp_timeout, 1);
            chk("to_rdata", rsp_rdata, 0);
            chk("to_psel", psel1, 0);
            chk("to_penable", penable1, 0);
        end
`else
        begin
            bit bad;
            bad = 1'b0;
            repeat (1000) begin
                tick();
                if (req_done !== '0 || penable1 !== 1'b1) bad = 1'b1;
            end
            chk("no_timeout_done", bad, 0);
            chk("no_timeout_psel", psel1, es);
            chk("no_timeout_flag", rsp_timeout, 0);
            preset1 = 1'b0;
            tick();
            preset1 = 1'b1;
        end
`endif
        req_valid = '0;
        tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
